cnn_batch_runner: RTL and testbench
===================================

Name: cnn_batch_runner

Overview:
- Hardware successor to the single-image CNN_top test fixture: sequences a parametrised batch of inference runs on the CNN core and checks each result.
- Per run: pulses start, waits for done with a cycle timeout, captures the class, compares it to an expected label and accumulates pass/fail/timeout counts and latency.
- Sits beside CNN_top in the top level and drives its start/handshake.
- Lets board tests and simulation benches run N images without a manual stop time.

Parameters:
- CLASS_W, 4, width of class result and expected label
- NUM_RUNS, 8, inferences per batch (1..2**IDX_W)
- IDX_W, 3, width of the run index
- TIMEOUT, 61000, cycles allowed from start to done (0.61 ms at 100 MHz)
- LAT_W, 17, latency counter width; must hold TIMEOUT
- GAP, 4, idle cycles between runs (0 allowed)

Ports:
- clk_in  in  1  system clock, 100 MHz
- rst_n  in  1  asynchronous active-low reset
- go  in  1  start a batch; sampled only in IDLE
- cnn_start  out  1  one-cycle start pulse to the CNN core
- cnn_done  in  1  core result-valid pulse
- cnn_class  in  CLASS_W  core class; valid when cnn_done=1
- exp_class  in  CLASS_W  expected label for run_idx; combinational from an external ROM
- run_idx  out  IDX_W  index of the current run
- busy  out  1  high from go acceptance until batch_done
- batch_done  out  1  one-cycle pulse when the batch completes
- pass_cnt  out  IDX_W+1  runs with class == expected
- fail_cnt  out  IDX_W+1  runs with class != expected
- tmo_cnt  out  IDX_W+1  runs that timed out
- last_class  out  CLASS_W  most recently captured class
- last_lat  out  LAT_W  cycles from cnn_start to cnn_done for the last good run

Behaviour:
- Reset (async assert, sync deassert inside the block) clears all outputs and counters to 0 and returns the FSM to IDLE.
- IDLE:
  - go=1 → clear pass/fail/tmo counts and run_idx, set busy, go to LAUNCH.
  - go while busy is ignored.
- LAUNCH:
  - cnn_start=1 for exactly one cycle.
  - Latency counter loaded to 1.
  - Go to WAIT.
- WAIT:
  - Latency counter increments each cycle.
  - cnn_done=1: latch cnn_class into last_class, latch the counter into last_lat, compare against exp_class in the same cycle, increment pass_cnt or fail_cnt, go to NEXT.
  - Counter reaches TIMEOUT without done: increment tmo_cnt; last_class and last_lat are unchanged; go to NEXT.
  - done and timeout in the same cycle: done wins.
  - cnn_done outside WAIT is ignored (stale or spurious pulses are dropped, never counted).
- NEXT:
  - Last run (run_idx == NUM_RUNS-1): pulse batch_done, drop busy, go to IDLE. Counters and run_idx hold until the next go.
  - Otherwise: run_idx++, then wait GAP cycles in a GAP state (skipped if GAP=0), then go to LAUNCH.
- Invariant: pass_cnt + fail_cnt + tmo_cnt == runs completed.
- Counters never wrap; at most NUM_RUNS increments.
- Reset asserted mid-batch aborts immediately with no batch_done.
- Latency of go → cnn_start: 1 cycle.

Optional Feature:
- Macro: CNN_BATCH_LAT_STATS_EN.
- Defined:
  - Adds outputs lat_min and lat_max (LAT_W each), updated on each good run.
  - lat_min resets to all-ones; lat_max resets to 0.
  - Both are re-initialised on go.
  - Timed-out runs do not update either.
- Undefined: the ports and logic are absent and the behaviour is otherwise identical.

Decomposition:
- Package cnn_pkg:
  - FSM state enum: IDLE, LAUNCH, WAIT, NEXT, GAP.
  - Default CLASS_W.
  - Constant CLK_HZ = 100_000_000.
- One sub-module, cnn_lat_timer: loadable saturating LAT_W up-counter with a terminal-count flag at TIMEOUT.

Test Plan:
- NUM_RUNS=4, core model answers after 500 cycles with class = exp_class on all runs → pass_cnt=4, fail_cnt=0, tmo_cnt=0, last_lat=500, one batch_done pulse, busy low afterwards.
- Run 2 answers class 3 against expected 5 → fail_cnt=1, pass_cnt=3, last_class=3 after run 2.
- Core never answers on run 1, TIMEOUT=100 → tmo_cnt=1; run 2 cnn_start occurs 100+GAP+1 cycles after run 1's start; last_lat is unchanged from run 0.
- cnn_done pulsed in IDLE and in GAP, and go pulsed while busy → no counter change, no extra cnn_start.
- rst_n dropped during WAIT of run 2 → all outputs 0 immediately, FSM in IDLE, no batch_done; a new go restarts from run_idx=0.
- With CNN_BATCH_LAT_STATS_EN, latencies 300/700/500 → lat_min=300, lat_max=700.

Source files
------------

// File: rtl/cnn_pkg.sv
// Shared types and constants for the CNN batch runner.
// Optional min/max latency statistics are enabled by defining CNN_BATCH_LAT_STATS_EN.
package cnn_pkg;

    // Default width of the class result and the expected label
    localparam int CNN_CLASS_W = 4;

    // Nominal system clock
    localparam int unsigned CLK_HZ = 100_000_000;

    // Batch sequencer states
    typedef enum logic [2:0] {
        S_IDLE,
        S_LAUNCH,
        S_WAIT,
        S_NEXT,
        S_GAP
    } run_state_e;

    // Width of a counter that must hold values 0..gap (at least one bit)
    function automatic int gap_width(input int gap);
        return (gap < 2) ? 1 : $clog2(gap + 1);
    endfunction

endpackage

// File: rtl/cnn_batch_runner_if.sv
// Handshake bundle between the batch runner (master) and the CNN core plus
// its expected-label ROM (slave side).
interface cnn_batch_runner_if
    import cnn_pkg::*;
#(
    parameter int CLASS_W = CNN_CLASS_W,
    parameter int IDX_W   = 3
);

    logic               cnn_start;
    logic               cnn_done;
    logic [CLASS_W-1:0] cnn_class;
    logic [CLASS_W-1:0] exp_class;
    logic [IDX_W-1:0]   run_idx;

    modport master (
        output cnn_start,
        output run_idx,
        input  cnn_done,
        input  cnn_class,
        input  exp_class
    );

    modport slave (
        input  cnn_start,
        input  run_idx,
        output cnn_done,
        output cnn_class,
        output exp_class
    );

endinterface

// File: rtl/cnn_lat_timer.sv
// Per-run latency timer: loadable up-counter that saturates at TIMEOUT.
// tc flags the cycle whose increment brings the count to TIMEOUT, so the
// sequencer can leave its wait state exactly TIMEOUT cycles after the start.
module cnn_lat_timer #(
    parameter int LAT_W   = 17,
    parameter int TIMEOUT = 61000
) (
    input  logic             clk_in,
    input  logic             rst_n,
    input  logic             load,
    input  logic             en,
    output logic [LAT_W-1:0] count,
    output logic             tc
);

    localparam logic [LAT_W-1:0] LIMIT = LAT_W'(TIMEOUT);

    // Count register: load to 1, then count up while enabled, holding at LIMIT
    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (load) begin
            // NOTE: sequential state always uses non-blocking assignment so every
            // flop samples pre-edge values regardless of block ordering.
            count <= LAT_W'(1);
        end else if (en && (count != LIMIT)) begin
            count <= count + 1'b1;
        end
    end

    assign tc = en && (count >= (LIMIT - 1'b1));

endmodule

// File: rtl/cnn_batch_runner.sv
// Batch sequencer for the CNN core: launches NUM_RUNS inferences, waits for
// each result with a timeout, checks the class against an external label ROM
// and accumulates pass/fail/timeout counts and the last good latency.
// Optional: define CNN_BATCH_LAT_STATS_EN to add lat_min/lat_max outputs.
module cnn_batch_runner
    import cnn_pkg::*;
#(
    parameter int CLASS_W  = CNN_CLASS_W,
    parameter int NUM_RUNS = 8,
    parameter int IDX_W    = 3,
    parameter int TIMEOUT  = 61000,
    parameter int LAT_W    = 17,
    parameter int GAP      = 4
) (
    input  logic                clk_in,
    input  logic                rst_n,
    input  logic                go,
    cnn_batch_runner_if.master  core,
    output logic                busy,
    output logic                batch_done,
    output logic [IDX_W:0]      pass_cnt,
    output logic [IDX_W:0]      fail_cnt,
    output logic [IDX_W:0]      tmo_cnt,
    output logic [CLASS_W-1:0]  last_class,
    output logic [LAT_W-1:0]    last_lat
`ifdef CNN_BATCH_LAT_STATS_EN
    ,
    output logic [LAT_W-1:0]    lat_min,
    output logic [LAT_W-1:0]    lat_max
`endif
);

    localparam int               GAP_W    = gap_width(GAP);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_RUNS - 1);

    logic [1:0]       rst_sync;
    logic             rst_int_n;
    run_state_e       state;
    run_state_e       state_nxt;
    logic [IDX_W-1:0] run_idx;
    logic [GAP_W-1:0] gap_cnt;
    logic [LAT_W-1:0] lat_cnt;
    logic             lat_tc;
    logic             cnn_start;
    logic             done_seen;
    logic             tmo_hit;
    logic             is_last;
    logic             go_accept;

    // Reset synchroniser: assert asynchronously, release on the clock
    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            rst_sync <= '0;
        end else begin
            rst_sync <= {rst_sync[0], 1'b1};
        end
    end

    assign rst_int_n = rst_sync[1];

    // Per-run latency / timeout counter
    cnn_lat_timer #(
        .LAT_W   (LAT_W),
        .TIMEOUT (TIMEOUT)
    ) u_lat_timer (
        .clk_in (clk_in),
        .rst_n  (rst_int_n),
        .load   (state == S_LAUNCH),
        .en     (state == S_WAIT),
        .count  (lat_cnt),
        .tc     (lat_tc)
    );

    // Result events only exist in WAIT; done takes priority over timeout
    assign go_accept = (state == S_IDLE) && go;
    assign done_seen = (state == S_WAIT) && core.cnn_done;
    assign tmo_hit   = (state == S_WAIT) && !core.cnn_done && lat_tc;
    assign is_last   = (run_idx == LAST_IDX);

    // FSM state register
    always_ff @(posedge clk_in or negedge rst_int_n) begin
        if (!rst_int_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state and state-decoded outputs
    always_comb begin
        // NOTE: every signal written here gets a default first so no path can
        // leave it unassigned and infer a latch.
        state_nxt  = state;
        cnn_start  = 1'b0;
        busy       = 1'b1;
        batch_done = 1'b0;
        unique case (state)
            S_IDLE: begin
                busy = 1'b0;
                if (go) state_nxt = S_LAUNCH;
            end
            S_LAUNCH: begin
                cnn_start = 1'b1;
                state_nxt = S_WAIT;
            end
            S_WAIT: begin
                if (core.cnn_done || lat_tc) state_nxt = S_NEXT;
            end
            S_NEXT: begin
                if (is_last) begin
                    batch_done = 1'b1;
                    state_nxt  = S_IDLE;
                end else if (GAP == 0) begin
                    state_nxt = S_LAUNCH;
                end else begin
                    state_nxt = S_GAP;
                end
            end
            S_GAP: begin
                if (gap_cnt == GAP_W'(GAP)) state_nxt = S_LAUNCH;
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    assign core.cnn_start = cnn_start;
    assign core.run_idx   = run_idx;

    // Run index, gap counter, result counts and last-result capture
    always_ff @(posedge clk_in or negedge rst_int_n) begin
        if (!rst_int_n) begin
            run_idx    <= '0;
            gap_cnt    <= '0;
            pass_cnt   <= '0;
            fail_cnt   <= '0;
            tmo_cnt    <= '0;
            last_class <= '0;
            last_lat   <= '0;
        end else begin
            if (go_accept) begin
                run_idx  <= '0;
                pass_cnt <= '0;
                fail_cnt <= '0;
                tmo_cnt  <= '0;
            end

            if (done_seen) begin
                last_class <= core.cnn_class;
                last_lat   <= lat_cnt;
                if (core.cnn_class == core.exp_class) begin
                    pass_cnt <= pass_cnt + 1'b1;
                end else begin
                    fail_cnt <= fail_cnt + 1'b1;
                end
            end else if (tmo_hit) begin
                tmo_cnt <= tmo_cnt + 1'b1;
            end

            if ((state == S_NEXT) && !is_last) begin
                run_idx <= run_idx + 1'b1;
            end

            if (state == S_NEXT) begin
                gap_cnt <= GAP_W'(1);
            end else if (state == S_GAP) begin
                gap_cnt <= gap_cnt + 1'b1;
            end
        end
    end

`ifdef CNN_BATCH_LAT_STATS_EN
    // Min/max latency over the good runs of the current batch
    always_ff @(posedge clk_in or negedge rst_int_n) begin
        if (!rst_int_n) begin
            lat_min <= '1;
            lat_max <= '0;
        end else if (go_accept) begin
            lat_min <= '1;
            lat_max <= '0;
        end else if (done_seen) begin
            if (lat_cnt < lat_min) lat_min <= lat_cnt;
            if (lat_cnt > lat_max) lat_max <= lat_cnt;
        end
    end
`endif

endmodule

// File: tb/tb_cnn_batch_runner.sv
// Self-checking bench for cnn_batch_runner: a behavioural core model answers
// each start after a per-run latency (or never), a table of hand-computed
// batches plus hand sequences covers the corners, and random batches are
// checked against a run-by-run reference model.
`timescale 1ns/1ps
module tb_cnn_batch_runner;
    import cnn_pkg::*;

    localparam int CLASS_W  = 4;
    localparam int NUM_RUNS = 4;
    localparam int IDX_W    = 2;
    localparam int TIMEOUT  = 800;
    localparam int LAT_W    = 17;
    localparam int GAP      = 4;
    localparam int BUDGET   = 12000;

    typedef struct packed {
        logic [NUM_RUNS-1:0][9:0]         lat;   // 0 = core never answers
        logic [NUM_RUNS-1:0][CLASS_W-1:0] cls;
        logic [NUM_RUNS-1:0][CLASS_W-1:0] exp;
        logic [IDX_W:0]                   e_pass;
        logic [IDX_W:0]                   e_fail;
        logic [IDX_W:0]                   e_tmo;
        logic [CLASS_W-1:0]               e_class;
        logic [LAT_W-1:0]                 e_lat;
    } vec_t;

    typedef struct packed {
        logic [IDX_W:0]     pass;
        logic [IDX_W:0]     fail;
        logic [IDX_W:0]     tmo;
        logic [CLASS_W-1:0] last_class;
        logic [LAT_W-1:0]   last_lat;
        logic [LAT_W-1:0]   lat_min;
        logic [LAT_W-1:0]   lat_max;
    } exp_t;

    logic               clk_in = 1'b0;
    logic               rst_n  = 1'b0;
    logic               go     = 1'b0;
    logic               busy;
    logic               batch_done;
    logic [IDX_W:0]     pass_cnt;
    logic [IDX_W:0]     fail_cnt;
    logic [IDX_W:0]     tmo_cnt;
    logic [CLASS_W-1:0] last_class;
    logic [LAT_W-1:0]   last_lat;
`ifdef CNN_BATCH_LAT_STATS_EN
    logic [LAT_W-1:0]   lat_min;
    logic [LAT_W-1:0]   lat_max;
`endif

    // Core model and label ROM contents for the batch being run
    int unsigned        run_lat [NUM_RUNS];
    logic [CLASS_W-1:0] run_cls [NUM_RUNS];
    logic [CLASS_W-1:0] exp_rom [NUM_RUNS];
    logic               model_done  = 1'b0;
    logic               spur_done   = 1'b0;
    logic [CLASS_W-1:0] model_class = '0;

    // Reference-model memory of the last good result (survives across batches)
    logic [CLASS_W-1:0] m_last_class = '0;
    logic [LAT_W-1:0]   m_last_lat   = '0;

    // Monitor bookkeeping
    int unsigned        cyc       = 0;
    int unsigned        start_cnt = 0;
    int unsigned        bdone_cnt = 0;
    int unsigned        start_cyc_q [$];
    logic [IDX_W-1:0]   start_idx_q [$];
    bit                 pend      = 1'b0;
    int unsigned        pend_age  = 0;
    int unsigned        pend_lat  = 0;

    int unsigned        n_chk = 0;
    int unsigned        n_err = 0;

    cnn_batch_runner_if #(.CLASS_W(CLASS_W), .IDX_W(IDX_W)) cnn_if ();

    assign cnn_if.cnn_done  = model_done | spur_done;
    assign cnn_if.cnn_class = model_class;
    assign cnn_if.exp_class = exp_rom[cnn_if.run_idx];

    cnn_batch_runner #(
        .CLASS_W  (CLASS_W),
        .NUM_RUNS (NUM_RUNS),
        .IDX_W    (IDX_W),
        .TIMEOUT  (TIMEOUT),
        .LAT_W    (LAT_W),
        .GAP      (GAP)
    ) dut (
        .clk_in     (clk_in),
        .rst_n      (rst_n),
        .go         (go),
        .core       (cnn_if),
        .busy       (busy),
        .batch_done (batch_done),
        .pass_cnt   (pass_cnt),
        .fail_cnt   (fail_cnt),
        .tmo_cnt    (tmo_cnt),
        .last_class (last_class),
        .last_lat   (last_lat)
`ifdef CNN_BATCH_LAT_STATS_EN
        ,
        .lat_min    (lat_min),
        .lat_max    (lat_max)
`endif
    );

    always #5 clk_in = ~clk_in;

    // Core model and monitor, evaluated mid-cycle: a start seen in cycle S
    // produces a one-cycle done in cycle S+lat.
    always @(negedge clk_in) begin
        cyc++;
        model_done = 1'b0;
        if (!rst_n) begin
            pend = 1'b0;
        end else begin
            if (pend) begin
                pend_age++;
                if (pend_age == pend_lat) begin
                    model_done = 1'b1;
                    pend       = 1'b0;
                end
            end
            if (cnn_if.cnn_start) begin
                start_cnt++;
                start_cyc_q.push_back(cyc);
                start_idx_q.push_back(cnn_if.run_idx);
                if (run_lat[cnn_if.run_idx] != 0) begin
                    pend        = 1'b1;
                    pend_age    = 0;
                    pend_lat    = run_lat[cnn_if.run_idx];
                    model_class = run_cls[cnn_if.run_idx];
                end
            end
            if (batch_done) bdone_cnt++;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, want %0d", name, act, exp);
        end
    endtask

    // Reference model: outcome of one batch from the run rules alone
    task automatic model_batch(output exp_t e);
        e = '0;
        e.lat_min = '1;
        for (int r = 0; r < NUM_RUNS; r++) begin
            if (run_lat[r] == 0 || run_lat[r] >= TIMEOUT) begin
                e.tmo++;
            end else begin
                if (run_cls[r] == exp_rom[r]) e.pass++;
                else                          e.fail++;
                m_last_class = run_cls[r];
                m_last_lat   = LAT_W'(run_lat[r]);
                if (m_last_lat < e.lat_min) e.lat_min = m_last_lat;
                if (m_last_lat > e.lat_max) e.lat_max = m_last_lat;
            end
        end
        e.last_class = m_last_class;
        e.last_lat   = m_last_lat;
    endtask

    function automatic vec_t mk(input int l0, l1, l2, l3,
                                input int c0, c1, c2, c3,
                                input int x0, x1, x2, x3,
                                input int ep, ef, et, ec, el);
        vec_t v;
        v.lat[0] = 10'(l0); v.lat[1] = 10'(l1); v.lat[2] = 10'(l2); v.lat[3] = 10'(l3);
        v.cls[0] = CLASS_W'(c0); v.cls[1] = CLASS_W'(c1);
        v.cls[2] = CLASS_W'(c2); v.cls[3] = CLASS_W'(c3);
        v.exp[0] = CLASS_W'(x0); v.exp[1] = CLASS_W'(x1);
        v.exp[2] = CLASS_W'(x2); v.exp[3] = CLASS_W'(x3);
        v.e_pass  = (IDX_W+1)'(ep);
        v.e_fail  = (IDX_W+1)'(ef);
        v.e_tmo   = (IDX_W+1)'(et);
        v.e_class = CLASS_W'(ec);
        v.e_lat   = LAT_W'(el);
        return v;
    endfunction

    task automatic load_vec(input vec_t v);
        for (int r = 0; r < NUM_RUNS; r++) begin
            run_lat[r] = v.lat[r];
            run_cls[r] = v.cls[r];
            exp_rom[r] = v.exp[r];
        end
    endtask

    task automatic load_uniform(input int unsigned lat);
        for (int r = 0; r < NUM_RUNS; r++) begin
            run_lat[r] = lat;
            exp_rom[r] = CLASS_W'(r + 1);
            run_cls[r] = CLASS_W'(r + 1);
        end
    endtask

    task automatic pulse_go();
        @(negedge clk_in); go = 1'b1;
        @(negedge clk_in); go = 1'b0;
    endtask

    task automatic wait_bdone(input int unsigned b0, input string tag);
        int unsigned n = 0;
        while (bdone_cnt == b0 && n < BUDGET) begin
            @(negedge clk_in);
            n++;
        end
        check({tag, "_finished"}, 32'(n < BUDGET), 1);
    endtask

    task automatic wait_starts(input int unsigned target, input string tag);
        int unsigned n = 0;
        while (start_cnt < target && n < BUDGET) begin
            @(negedge clk_in);
            n++;
        end
        check({tag, "_launched"}, 32'(n < BUDGET), 1);
    endtask

    task automatic check_batch(input string tag, input int unsigned s0, input int unsigned b0,
                               input exp_t e);
        repeat (3) @(negedge clk_in);
        check({tag, "_starts"},     start_cnt - s0, NUM_RUNS);
        check({tag, "_bdone"},      bdone_cnt - b0, 1);
        check({tag, "_busy"},       32'(busy), 0);
        check({tag, "_pass"},       32'(pass_cnt), 32'(e.pass));
        check({tag, "_fail"},       32'(fail_cnt), 32'(e.fail));
        check({tag, "_tmo"},        32'(tmo_cnt), 32'(e.tmo));
        check({tag, "_last_class"}, 32'(last_class), 32'(e.last_class));
        check({tag, "_last_lat"},   32'(last_lat), 32'(e.last_lat));
`ifdef CNN_BATCH_LAT_STATS_EN
        check({tag, "_lat_min"},    32'(lat_min), 32'(e.lat_min));
        check({tag, "_lat_max"},    32'(lat_max), 32'(e.lat_max));
`endif
    endtask

    initial begin
        vec_t        tbl [6];
        exp_t        e;
        exp_t        et;
        int unsigned s0;
        int unsigned b0;
        int unsigned c0;
        logic [IDX_W:0] p_snap;
        logic [IDX_W:0] f_snap;
        logic [IDX_W:0] t_snap;

        load_uniform(100);

        // Reset state
        repeat (3) @(negedge clk_in);
        check("rst_busy",       32'(busy), 0);
        check("rst_start",      32'(cnn_if.cnn_start), 0);
        check("rst_bdone",      32'(batch_done), 0);
        check("rst_counts",     32'({pass_cnt, fail_cnt, tmo_cnt}), 0);
        check("rst_last",       32'({last_class, last_lat}), 0);
        check("rst_run_idx",    32'(cnn_if.run_idx), 0);
`ifdef CNN_BATCH_LAT_STATS_EN
        check("rst_lat_min",    32'(lat_min), 32'((1 << LAT_W) - 1));
        check("rst_lat_max",    32'(lat_max), 0);
`endif
        rst_n = 1'b1;
        repeat (5) @(negedge clk_in);

        // Hand-computed batches: {latencies, classes, labels, expected results}
        tbl[0] = mk(500, 500, 500, 500,  1, 2, 3, 4,  1, 2, 3, 4,  4, 0, 0, 4, 500);
        tbl[1] = mk(500, 450, 520, 480,  7, 6, 3, 9,  7, 6, 5, 9,  3, 1, 0, 9, 480);
        tbl[2] = mk(300,   0, 250, 400,  2, 2, 2, 2,  2, 2, 2, 2,  3, 0, 1, 2, 400);
        tbl[3] = mk(  1, 799, 800,   2,  1,15, 8, 3,  0,15, 8, 3,  2, 1, 1, 3,   2);
        tbl[4] = mk(300, 700, 500, 600,  5, 5, 5, 5,  5, 5, 5, 5,  4, 0, 0, 5, 600);
        tbl[5] = mk(  0,   0,   0,   0,  1, 1, 1, 1,  1, 1, 1, 1,  0, 0, 4, 5, 600);

        for (int i = 0; i < 6; i++) begin
            load_vec(tbl[i]);
            model_batch(e);
            et            = e;
            et.pass       = tbl[i].e_pass;
            et.fail       = tbl[i].e_fail;
            et.tmo        = tbl[i].e_tmo;
            et.last_class = tbl[i].e_class;
            et.last_lat   = tbl[i].e_lat;
            s0 = start_cnt;
            b0 = bdone_cnt;
            pulse_go();
            wait_bdone(b0, $sformatf("vec%0d", i));
            check_batch($sformatf("vec%0d", i), s0, b0, et);
        end

        // Stray done in IDLE, go->start latency, stray done in GAP, go while busy
        load_uniform(100);
        s0 = start_cnt;
        b0 = bdone_cnt;
        p_snap = pass_cnt; f_snap = fail_cnt; t_snap = tmo_cnt;
        @(negedge clk_in); spur_done = 1'b1;
        @(negedge clk_in); spur_done = 1'b0;
        repeat (2) @(negedge clk_in);
        check("idle_done_counts", 32'({pass_cnt, fail_cnt, tmo_cnt}), 32'({p_snap, f_snap, t_snap}));
        check("idle_done_starts", start_cnt - s0, 0);
        model_batch(e);
        @(negedge clk_in); go = 1'b1;
        @(negedge clk_in);
        check("go_to_start", 32'(cnn_if.cnn_start), 1);
        go = 1'b0;
        c0 = cyc;
        while (cyc < c0 + 102) @(negedge clk_in);
        spur_done = 1'b1;
        go        = 1'b1;
        @(negedge clk_in);
        spur_done = 1'b0;
        go        = 1'b0;
        wait_bdone(b0, "spur");
        check_batch("spur", s0, b0, e);

        // Mismatch on run 2 is visible once run 3 launches
        load_vec(tbl[1]);
        model_batch(e);
        s0 = start_cnt;
        b0 = bdone_cnt;
        pulse_go();
        wait_starts(s0 + 4, "mis");
        check("mis_mid_class", 32'(last_class), 3);
        check("mis_mid_fail",  32'(fail_cnt), 1);
        check("mis_mid_pass",  32'(pass_cnt), 2);
        wait_bdone(b0, "mis");
        check_batch("mis", s0, b0, e);

        // Timeout on run 1: start spacing and unchanged last result
        load_vec(tbl[2]);
        model_batch(e);
        s0 = start_cnt;
        b0 = bdone_cnt;
        pulse_go();
        wait_starts(s0 + 3, "tmo");
        check("tmo_spacing",  start_cyc_q[s0 + 2] - start_cyc_q[s0 + 1], TIMEOUT + GAP + 1);
        check("tmo_mid_lat",  32'(last_lat), 300);
        check("tmo_mid_cnt",  32'(tmo_cnt), 1);
        wait_bdone(b0, "tmo");
        check_batch("tmo", s0, b0, e);

        // Reset during WAIT of run 2 aborts the batch
        load_uniform(500);
        s0 = start_cnt;
        b0 = bdone_cnt;
        pulse_go();
        wait_starts(s0 + 3, "abort");
        repeat (100) @(negedge clk_in);
        rst_n = 1'b0;
        #1;
        check("abort_busy",    32'(busy), 0);
        check("abort_counts",  32'({pass_cnt, fail_cnt, tmo_cnt}), 0);
        check("abort_last",    32'({last_class, last_lat}), 0);
        check("abort_run_idx", 32'(cnn_if.run_idx), 0);
        check("abort_start",   32'(cnn_if.cnn_start), 0);
`ifdef CNN_BATCH_LAT_STATS_EN
        check("abort_lat_min", 32'(lat_min), 32'((1 << LAT_W) - 1));
`endif
        m_last_class = '0;
        m_last_lat   = '0;
        repeat (5) @(negedge clk_in);
        rst_n = 1'b1;
        repeat (5) @(negedge clk_in);
        check("abort_no_bdone", bdone_cnt - b0, 0);
        load_uniform(200);
        model_batch(e);
        s0 = start_cnt;
        b0 = bdone_cnt;
        pulse_go();
        wait_bdone(b0, "restart");
        check("restart_idx0", 32'(start_idx_q[s0]), 0);
        check_batch("restart", s0, b0, e);

        // Randomised batches against the reference model
        for (int b = 0; b < 3; b++) begin
            for (int r = 0; r < NUM_RUNS; r++) begin
                run_lat[r] = ($urandom_range(0, 7) == 0) ? 0 : $urandom_range(1, 900);
                exp_rom[r] = CLASS_W'($urandom_range(0, (1 << CLASS_W) - 1));
                run_cls[r] = ($urandom_range(0, 1) == 1) ? exp_rom[r]
                                                         : CLASS_W'($urandom_range(0, (1 << CLASS_W) - 1));
            end
            model_batch(e);
            s0 = start_cnt;
            b0 = bdone_cnt;
            pulse_go();
            wait_bdone(b0, $sformatf("rnd%0d", b));
            check_batch($sformatf("rnd%0d", b), s0, b0, e);
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
